multi_port_register_file: RTL

Parametrised successor to the team's 32x32 dual-port register file. Provides 2 write ports, NUM_RD read ports, optional hardwired-zero register, write-to-read bypass, optional registered reads, and a per-entry busy scoreboard with an occupancy counter. It sits in the datapath between decode/issue (reads, reservations) and writeback (writes).

---
 rtl/multi_port_register_file_if.sv | 30 +++
 rtl/multi_port_register_file.sv | 121 ++++++++++++
 2 files changed

// File: rtl/multi_port_register_file_if.sv
// Register-file access bundle: write ports, packed read ports, reservation
// port and scoreboard status returned to the issue stage.
interface multi_port_register_file_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2
);
    logic                     we0;
    logic                     we1;
    logic [ADDR_W-1:0]        wa0;
    logic [ADDR_W-1:0]        wa1;
    logic [DATA_W-1:0]        wd0;
    logic [DATA_W-1:0]        wd1;
    logic [NUM_RD*ADDR_W-1:0] ra;
    logic [NUM_RD*DATA_W-1:0] rd;
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;
    logic [NUM_RD-1:0]        busy_rd;
    logic [ADDR_W:0]          busy_cnt;

    modport master (
        output we0, we1, wa0, wa1, wd0, wd1, ra, rsv_en, rsv_addr,
        input  rd, busy_rd, busy_cnt
    );

    modport slave (
        input  we0, we1, wa0, wa1, wd0, wd1, ra, rsv_en, rsv_addr,
        output rd, busy_rd, busy_cnt
    );
endinterface

// File: rtl/multi_port_register_file.sv
// Two-write, NUM_RD-read register file with optional zero register, write
// bypass, registered reads and a per-entry busy scoreboard with occupancy count.
module multi_port_register_file #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          RD_REG   = 1'b0
) (
    input logic                        clk,
    input logic                        reset,
    multi_port_register_file_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic [DATA_W-1:0]        mem_d [DEPTH];
    logic [DEPTH-1:0]         busy_q;
    logic [DEPTH-1:0]         busy_d;
    logic [CNT_W-1:0]         busy_cnt_q;
    logic [CNT_W-1:0]         busy_cnt_d;
    logic [NUM_RD*DATA_W-1:0] rd_d;
    logic [NUM_RD-1:0]        busy_rd_d;

    logic wr0_ok;
    logic wr1_ok;
    logic rsv_ok;
    logic cnt_inc;
    logic cnt_clr0;
    logic cnt_clr1;

    // Qualify requests; entry 0 swallows writes and reservations when hardwired.
    always_comb begin
        wr0_ok = bus.we0    && !(ZERO_REG && (bus.wa0 == '0));
        wr1_ok = bus.we1    && !(ZERO_REG && (bus.wa1 == '0));
        rsv_ok = bus.rsv_en && !(ZERO_REG && (bus.rsv_addr == '0));
    end

    // Next-state storage: port 1 applied last so it wins a collision; the
    // reservation is applied after the write clears so the new producer wins.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (wr0_ok) begin
            mem_d[bus.wa0]  = bus.wd0;
            busy_d[bus.wa0] = 1'b0;
        end
        if (wr1_ok) begin
            mem_d[bus.wa1]  = bus.wd1;
            busy_d[bus.wa1] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[bus.rsv_addr] = 1'b1;
        end
    end

    // Incremental occupancy: only real 0->1 and 1->0 transitions move the count.
    always_comb begin
        cnt_inc  = rsv_ok && !busy_q[bus.rsv_addr];
        cnt_clr0 = wr0_ok && busy_q[bus.wa0]
                   && !(rsv_ok && (bus.rsv_addr == bus.wa0));
        cnt_clr1 = wr1_ok && busy_q[bus.wa1]
                   && !(rsv_ok && (bus.rsv_addr == bus.wa1))
                   && !(wr0_ok && (bus.wa0 == bus.wa1));
        busy_cnt_d = busy_cnt_q + CNT_W'(cnt_inc) - CNT_W'(cnt_clr0) - CNT_W'(cnt_clr1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q      <= '{default: '0};
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Read mux: bypass selects the post-edge view of data and busy bits.
    always_comb begin
        logic [ADDR_W-1:0] ra_i;
        rd_d      = '0;
        busy_rd_d = '0;
        ra_i      = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            ra_i = bus.ra[i*ADDR_W +: ADDR_W];
            if (!(ZERO_REG && (ra_i == '0))) begin
                rd_d[i*DATA_W +: DATA_W] = BYPASS ? mem_d[ra_i]  : mem_q[ra_i];
                busy_rd_d[i]             = BYPASS ? busy_d[ra_i] : busy_q[ra_i];
            end
        end
    end

    generate
        if (RD_REG) begin : g_rd_reg
            logic [NUM_RD*DATA_W-1:0] rd_q;
            logic [NUM_RD-1:0]        busy_rd_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rd_q      <= '0;
                    busy_rd_q <= '0;
                end else begin
                    rd_q      <= rd_d;
                    busy_rd_q <= busy_rd_d;
                end
            end

            assign bus.rd      = rd_q;
            assign bus.busy_rd = busy_rd_q;
        end else begin : g_rd_comb
            assign bus.rd      = rd_d;
            assign bus.busy_rd = busy_rd_d;
        end
    endgenerate

    assign bus.busy_cnt = busy_cnt_q;
endmodule
